fifo_param: RTL and testbench

Parametrised synchronous FIFO: the next generation of the 8-bit × 16 UART buffer FIFO, generalised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode: first-word-fall-through or registered read. It sits between the UART RX/TX engines and their consumers/producers and is a drop-in replacement for the existing push/pop FIFO.

---
 rtl/fifo_param.sv | 122 ++++++++++++
 tb/tb_fifo_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with count, thresholds, sticky errors, flush and FWFT/registered read
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;

  // A push at full is still legal when a pop frees the slot on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok) count_d = count_q + CW'(1);
      if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      if (push && !push_ok) overflow_d  = 1'b1;
      if (pop && !pop_ok)   underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= w_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign r_data  = empty ? '0 : mem_q[rd_ptr_q];
      assign r_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_data_q;
      logic                  r_valid_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else if (clr) begin
          r_valid_q <= 1'b0;
        end else if (pop_ok) begin
          r_data_q  <= mem_q[rd_ptr_q];
          r_valid_q <= 1'b1;
        end else begin
          r_valid_q <= 1'b0;
        end
      end

      assign r_data  = r_data_q;
      assign r_valid = r_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized queue-model bench for fifo_param in FWFT and registered-read builds
module tb_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_push = 0, a_pop = 0, a_clr = 0;
  logic [7:0]  a_wd = 0;
  logic [7:0]  a_rdata;
  logic        a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_count;

  logic        b_push = 0, b_pop = 0, b_clr = 0;
  logic [11:0] b_wd = 0;
  logic [11:0] b_rdata;
  logic        b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_count;

  fifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .clr(a_clr), .w_data(a_wd),
    .r_data(a_rdata), .r_valid(a_rvalid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_param #(.DATA_WIDTH(12), .DEPTH(4), .FWFT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .clr(b_clr), .w_data(b_wd),
    .r_data(b_rdata), .r_valid(b_rvalid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain queues plus sticky flags and the registered-read output of B.
  logic [7:0]  qa[$];
  bit          m_a_ovf = 0, m_a_unf = 0;
  int          a_pushes = 0;
  logic [11:0] qb[$];
  bit          m_b_ovf = 0, m_b_unf = 0;
  logic [11:0] m_b_rd = 0;
  bit          m_b_rv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); m_a_ovf = 0; m_a_unf = 0;
    qb.delete(); m_b_ovf = 0; m_b_unf = 0; m_b_rd = 0; m_b_rv = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit pok, wok;
    if (a_clr) begin
      qa.delete(); m_a_ovf = 0; m_a_unf = 0;
    end else begin
      sz  = qa.size();
      pok = a_pop && sz > 0;
      wok = a_push && (sz < 16 || a_pop);
      if (pok) void'(qa.pop_front());
      if (wok) begin qa.push_back(a_wd); a_pushes++; end
      if (a_push && !wok) m_a_ovf = 1;
      if (a_pop && !pok)  m_a_unf = 1;
    end
    if (b_clr) begin
      qb.delete(); m_b_ovf = 0; m_b_unf = 0; m_b_rv = 0;
    end else begin
      sz  = qb.size();
      pok = b_pop && sz > 0;
      wok = b_push && (sz < 4 || b_pop);
      if (pok) begin m_b_rd = qb[0]; m_b_rv = 1; void'(qb.pop_front()); end
      else m_b_rv = 0;
      if (wok) qb.push_back(b_wd);
      if (b_push && !wok) m_b_ovf = 1;
      if (b_pop && !pok)  m_b_unf = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic a_op(input bit p, input bit q, input bit c, input logic [7:0] wd);
    a_push = p; a_pop = q; a_clr = c; a_wd = wd;
    tick();
    a_push = 0; a_pop = 0; a_clr = 0;
  endtask

  task automatic b_op(input bit p, input bit q, input bit c, input logic [11:0] wd);
    b_push = p; b_pop = q; b_clr = c; b_wd = wd;
    tick();
    b_push = 0; b_pop = 0; b_clr = 0;
  endtask

  logic [7:0] exp_a_rd;
  always @(negedge clk) begin
    exp_a_rd = (qa.size() != 0) ? qa[0] : 8'h00;
    chk("A.count",  a_count,  qa.size());
    chk("A.full",   a_full,   qa.size() == 16);
    chk("A.empty",  a_empty,  qa.size() == 0);
    chk("A.af",     a_af,     qa.size() >= 14);
    chk("A.ae",     a_ae,     qa.size() <= 2);
    chk("A.ovf",    a_ovf,    m_a_ovf);
    chk("A.unf",    a_unf,    m_a_unf);
    chk("A.rvalid", a_rvalid, qa.size() != 0);
    chk("A.rdata",  a_rdata,  exp_a_rd);
    chk("B.count",  b_count,  qb.size());
    chk("B.full",   b_full,   qb.size() == 4);
    chk("B.empty",  b_empty,  qb.size() == 0);
    chk("B.af",     b_af,     qb.size() >= 2);
    chk("B.ae",     b_ae,     qb.size() <= 2);
    chk("B.ovf",    b_ovf,    m_b_ovf);
    chk("B.unf",    b_unf,    m_b_unf);
    chk("B.rvalid", b_rvalid, m_b_rv);
    chk("B.rdata",  b_rdata,  m_b_rd);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.empty", a_empty, 1);
    chk("rst.ae",    a_ae,    1);
    chk("rst.rdata", a_rdata, 0);
    chk("rst.b_rv",  b_rvalid, 0);
    rst = 1'b1;

    // Fill past full.
    a_op(0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      a_op(1, 0, 0, 8'(i));
      if (i == 12) chk("fill.af13", a_af, 0);
      if (i == 13) chk("fill.af14", a_af, 1);
      if (i == 14) chk("fill.full15", a_full, 0);
      if (i == 15) begin chk("fill.full", a_full, 1); chk("fill.count", a_count, 16); chk("fill.ovf0", a_ovf, 0); end
      if (i == 16) begin chk("fill.ovf", a_ovf, 1); chk("fill.count17", a_count, 16); end
    end

    // Drain past empty.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) chk("drain.data", a_rdata, i);
      a_op(0, 1, 0, 0);
      if (i == 12) chk("drain.ae3", a_ae, 0);
      if (i == 13) chk("drain.ae2", a_ae, 1);
      if (i == 15) begin chk("drain.empty", a_empty, 1); chk("drain.unf0", a_unf, 0); end
      if (i == 16) chk("drain.unf", a_unf, 1);
    end

    // Push and pop together at full, then at empty.
    a_op(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) a_op(1, 0, 0, 8'(8'h10 + i));
    a_op(1, 1, 0, 8'hA5);
    chk("pp_full.count", a_count, 16);
    chk("pp_full.ovf",   a_ovf,   0);
    chk("pp_full.head",  a_rdata, 8'h11);
    a_op(0, 0, 1, 0);
    a_op(1, 1, 0, 8'h3C);
    chk("pp_empty.unf",   a_unf,   1);
    chk("pp_empty.count", a_count, 1);
    chk("pp_empty.rdata", a_rdata, 8'h3C);

    // Registered read on the 12-bit x 4 instance.
    b_op(0, 0, 1, 0);
    b_op(1, 0, 0, 12'h123);
    b_op(1, 0, 0, 12'h456);
    chk("reg.rv_before", b_rvalid, 0);
    b_op(0, 1, 0, 0);
    chk("reg.rv",    b_rvalid, 1);
    chk("reg.rdata", b_rdata,  12'h123);
    b_op(0, 0, 0, 0);
    chk("reg.rv_drop",  b_rvalid, 0);
    chk("reg.rd_hold",  b_rdata,  12'h123);

    // Flush beats a simultaneous push.
    a_op(0, 0, 1, 0);
    for (int i = 0; i < 17; i++) a_op(1, 0, 0, 8'(i));
    for (int i = 0; i < 11; i++) a_op(0, 1, 0, 0);
    chk("flush.count5", a_count, 5);
    chk("flush.ovf1",   a_ovf,   1);
    a_op(1, 0, 1, 8'h99);
    chk("flush.count", a_count, 0);
    chk("flush.empty", a_empty, 1);
    chk("flush.ovf",   a_ovf,   0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) a_op(1, 0, 0, 8'(8'h40 + i));
    b_op(1, 0, 0, 12'hABC);
    b_op(0, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk("arst.count",  a_count,  0);
    chk("arst.empty",  a_empty,  1);
    chk("arst.full",   a_full,   0);
    chk("arst.ae",     a_ae,     1);
    chk("arst.af",     a_af,     0);
    chk("arst.rvalid", a_rvalid, 0);
    chk("arst.rdata",  a_rdata,  0);
    chk("arst.b_rv",   b_rvalid, 0);
    chk("arst.b_rd",   b_rdata,  0);
    model_reset();
    #1 rst = 1'b1;
    a_op(1, 0, 0, 8'h77);
    chk("arst.first_count", a_count, 1);
    chk("arst.first_data",  a_rdata, 8'h77);

    // Random traffic gated by occupancy: no error flags may appear.
    a_clr = 1; b_clr = 1; tick(); a_clr = 0; b_clr = 0;
    a_pushes = 0;
    for (int n = 0; n < 1000; n++) begin
      a_push = ($urandom_range(0, 1) == 1) && (qa.size() < 16);
      a_pop  = ($urandom_range(0, 1) == 1) && (qa.size() > 0);
      a_wd   = 8'($urandom);
      b_push = ($urandom_range(0, 1) == 1) && (qb.size() < 4);
      b_pop  = ($urandom_range(0, 1) == 1) && (qb.size() > 0);
      b_wd   = 12'($urandom);
      tick();
    end
    chk("rand.wraps", a_pushes >= 160, 1);
    chk("rand.a_ovf", a_ovf, 0);
    chk("rand.a_unf", a_unf, 0);
    chk("rand.b_ovf", b_ovf, 0);
    chk("rand.b_unf", b_unf, 0);

    // Ungated random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      a_push = $urandom_range(0, 1) == 1;
      a_pop  = $urandom_range(0, 2) == 0;
      a_clr  = $urandom_range(0, 40) == 0;
      a_wd   = 8'($urandom);
      b_push = $urandom_range(0, 2) == 0;
      b_pop  = $urandom_range(0, 1) == 1;
      b_clr  = $urandom_range(0, 40) == 0;
      b_wd   = 12'($urandom);
      tick();
    end
    a_push = 0; a_pop = 0; a_clr = 0; b_push = 0; b_pop = 0; b_clr = 0;
    tick();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
